// File: rtl/ibex_icache_fetch_pkg.sv
// Shared types for the icache fetch buffer: buffered entry layout, has-addr states, PC step rule.
// Combinational helpers only; no state lives here.
package ibex_icache_fetch_pkg;

  typedef struct packed {
    logic [31:0] rdata;
    logic [31:0] addr;
    logic        err;
    logic        err_plus2;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    EMPTY_NOADDR = 2'd0,
    RUN          = 2'd1,
    HALT         = 2'd2
  } fetch_state_e;

  // Compressed instructions (low bits != 2'b11) are 2 bytes long, all others 4.
  function automatic logic [31:0] next_pc(input logic [31:0] addr, input logic [1:0] rdata_lo);
    return addr + ((rdata_lo != 2'b11) ? 32'd2 : 32'd4);
  endfunction

endpackage

// File: rtl/ibex_icache_fetch_fifo.sv
// DEPTH-entry circular buffer of fetch_entry_t with push/pop/flush; head visible the cycle after push.
// Caller must not push when full or pop when empty; flush overrides both in the same cycle.
module ibex_icache_fetch_fifo
  import ibex_icache_fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          flush_i,
  input  fetch_entry_t  wdata_i,
  output fetch_entry_t  head_o,
  output logic [CW-1:0] occupancy_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t   mem_q [DEPTH];
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;

  // Explicit wrap keeps non-power-of-two depths correct.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop_i)  rd_ptr_d = ptr_inc(rd_ptr_q);
      if (push_i && !pop_i) begin
        count_d = count_q + CW'(1);
      end else if (!push_i && pop_i) begin
        count_d = count_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_q <= '{default: '0};
    end else if (push_i && !flush_i) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  assign head_o      = mem_q[rd_ptr_q];
  assign occupancy_o = count_q;

endmodule

// File: rtl/ibex_icache_fetch_buffer.sv
// Core-side icache response consumer: gates ready/branch, buffers accepted words for decode (1-cycle push-to-head).
// ready_o drops when full/halted/branching with no path from out_ready_i; IBEX_FETCH_PC_CHECK_EN adds a PC checker.
module ibex_icache_fetch_buffer
  import ibex_icache_fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          req_i,
  input  logic          branch_i,
  input  logic [31:0]   branch_addr_i,
  output logic          branch_o,
  output logic [31:0]   branch_addr_o,
  output logic          ready_o,
  input  logic          valid_i,
  input  logic [31:0]   rdata_i,
  input  logic [31:0]   addr_i,
  input  logic          err_i,
  input  logic          err_plus2_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [31:0]   out_rdata_o,
  output logic [31:0]   out_addr_o,
  output logic          out_err_o,
  output logic          out_err_plus2_o,
  output logic          out_compressed_o,
  output logic [CW-1:0] occupancy_o,
  output logic          pc_mismatch_o
);

  fetch_state_e  state_q, state_d;
  fetch_entry_t  wdata, head;
  logic [CW-1:0] occupancy;
  logic          has_addr, not_full, nonempty, accept, pop;

  assign branch_o      = branch_i;
  assign branch_addr_o = branch_addr_i;

  assign has_addr = (state_q == RUN);
  assign not_full = (occupancy < CW'(DEPTH));
  assign nonempty = (occupancy != '0);

  // A branch cycle cancels whatever the cache presents and hides the stale head.
  assign ready_o     = req_i & has_addr & ~branch_i & not_full;
  assign accept      = ready_o & valid_i;
  assign out_valid_o = nonempty & ~branch_i;
  assign pop         = out_valid_o & out_ready_i;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY_NOADDR: if (branch_i) state_d = RUN;
      RUN: begin
        if (branch_i) begin
          state_d = RUN;
        end else if (accept && err_i) begin
          state_d = HALT;
        end
      end
      HALT:    if (branch_i) state_d = RUN;
      default: state_d = EMPTY_NOADDR;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= EMPTY_NOADDR;
    end else begin
      state_q <= state_d;
    end
  end

  assign wdata = '{rdata: rdata_i, addr: addr_i, err: err_i, err_plus2: err_plus2_i};

  ibex_icache_fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (accept),
    .pop_i       (pop),
    .flush_i     (branch_i),
    .wdata_i     (wdata),
    .head_o      (head),
    .occupancy_o (occupancy)
  );

  // Head fields read as zero while empty so stale storage never leaks to decode.
  assign out_rdata_o      = nonempty ? head.rdata : '0;
  assign out_addr_o       = nonempty ? head.addr  : '0;
  assign out_err_o        = nonempty & head.err;
  assign out_err_plus2_o  = nonempty & head.err_plus2;
  assign out_compressed_o = nonempty & ~head.err & (head.rdata[1:0] != 2'b11);
  assign occupancy_o      = occupancy;

`ifdef IBEX_FETCH_PC_CHECK_EN
  logic [31:0] expected_pc_q, expected_pc_d;
  logic        pc_mismatch_q, pc_mismatch_d;

  // Error accepts are compared but do not advance the expected PC.
  always_comb begin
    expected_pc_d = expected_pc_q;
    pc_mismatch_d = 1'b0;
    if (branch_i) begin
      expected_pc_d = branch_addr_i;
    end else if (accept) begin
      pc_mismatch_d = (addr_i != expected_pc_q);
      if (!err_i) expected_pc_d = next_pc(expected_pc_q, rdata_i[1:0]);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      expected_pc_q <= '0;
      pc_mismatch_q <= 1'b0;
    end else begin
      expected_pc_q <= expected_pc_d;
      pc_mismatch_q <= pc_mismatch_d;
    end
  end

  assign pc_mismatch_o = pc_mismatch_q;
`else
  assign pc_mismatch_o = 1'b0;
`endif

endmodule
